// File: rtl/dma_copy_engine_if.sv
// Master-port bundle between the DMA engine and the address-decoding interconnect.
// Handshake: bus_req/bus_gnt is a same-cycle request/grant; a bus access happens only in a cycle with bus_gnt=1.
interface dma_copy_engine_if #(
  parameter int WIDTH = 32
);
  logic             bus_req;
  logic             bus_gnt;
  logic             we_m;
  logic [WIDTH-1:0] addr_m;
  logic [WIDTH-1:0] wd_m;
  logic [WIDTH-1:0] rd_m;

  modport master (
    output bus_req,
    output we_m,
    output addr_m,
    output wd_m,
    input  bus_gnt,
    input  rd_m
  );

  modport slave (
    input  bus_req,
    input  we_m,
    input  addr_m,
    input  wd_m,
    output bus_gnt,
    output rd_m
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Single-channel DMA: word copy (src->dst) or word fill (pattern->dst) over the shared master port.
// bus_gnt is combinational, so every bus output is gated by it within the same cycle.
module dma_copy_engine #(
  parameter int WIDTH     = 32,
  parameter int ADDR_STEP = 4,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  dma_copy_engine_if.master bus,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_left,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] src_q, dst_q, data_q, pat_q;
  logic [LEN_W-1:0] cnt_q;
  logic             mode_q, fresh_q, abort_q;
  logic             abort_pend;
  logic             last_word;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(ADDR_STEP);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  // abort is honoured in the cycle it arrives as well as every later busy cycle
  assign abort_pend = abort_q | abort;
  assign last_word  = (cnt_q <= ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0)  state_d = DONE;
          else if (mode)  state_d = WR;
          else            state_d = RD;
        end
      end
      RD: begin
        if (abort_pend)       state_d = DONE;
        else if (bus.bus_gnt) state_d = WR;
      end
      WR: begin
        if (bus.bus_gnt) begin
          if (last_word || abort_pend) state_d = DONE;
          else if (!mode_q)            state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req = 1'b0;
    bus.we_m    = 1'b0;
    bus.addr_m  = '0;
    bus.wd_m    = '0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    aborted     = (state_q == DONE) && abort_q;
    case (state_q)
      RD: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt && !abort_pend) begin
          bus.addr_m = src_q;
        end
      end
      WR: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) begin
          bus.we_m   = 1'b1;
          bus.addr_m = dst_q;
          // first WR cycle after a read sees the slave data directly on rd_m
          if (mode_q)       bus.wd_m = pat_q;
          else if (fresh_q) bus.wd_m = bus.rd_m;
          else              bus.wd_m = data_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      pat_q   <= '0;
      mode_q  <= 1'b0;
      fresh_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            cnt_q   <= len;
            pat_q   <= fill_data;
            mode_q  <= mode;
            fresh_q <= 1'b0;
            abort_q <= 1'b0;
          end
        end
        RD: begin
          abort_q <= abort_pend;
          if (bus.bus_gnt && !abort_pend) begin
            src_q   <= src_q + STEP;
            fresh_q <= 1'b1;
          end
        end
        WR: begin
          abort_q <= abort_pend;
          // rd_m is only valid in the first WR cycle; keep it across a lost grant
          if (fresh_q) begin
            data_q  <= bus.rd_m;
            fresh_q <= 1'b0;
          end
          if (bus.bus_gnt) begin
            dst_q <= dst_q + STEP;
            if (cnt_q != '0) cnt_q <= cnt_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign words_left = cnt_q;
  assign state_dbg  = state_q;

endmodule
